// File: rtl/mac_pkg.sv
// Shared definitions for the MAC processing-element family: saturation modes,
// accumulator range limits and a width sanity check.
`ifndef MAC_PKG_SV
`define MAC_PKG_SV

// Elaboration-time guard: the full-width product must fit in the accumulator.
`define MAC_WIDTH_CHECK(DW_, ACC_W_) \
    if ((ACC_W_) < 2 * (DW_)) begin : g_bad_width \
        $error("mac: ACC_W must be at least 2*DW"); \
    end

package mac_pkg;

    typedef enum logic {
        MAC_WRAP = 1'b0,
        MAC_SAT  = 1'b1
    } mac_sat_t;

    localparam int MAC_MAX_ACC_W = 64;

    // Signed max (want_max=1) or min of an acc_w-bit value, in the low acc_w bits.
    function automatic logic [MAC_MAX_ACC_W-1:0] acc_limit(input int acc_w, input logic want_max);
        logic [MAC_MAX_ACC_W-1:0] lim;
        lim = (64'd1 << (acc_w - 1)) - 64'd1;
        return want_max ? lim : ~lim;
    endfunction

endpackage

`endif

// File: rtl/mac_sat_add.sv
// Combinational signed ACC_W-bit adder with optional clamping and an overflow flag.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int       ACC_W = 24,
    parameter mac_sat_t MODE  = MAC_SAT
) (
    input  logic signed [ACC_W-1:0] x,
    input  logic signed [ACC_W-1:0] y,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    localparam logic [MAC_MAX_ACC_W-1:0] MAX64 = acc_limit(ACC_W, 1'b1);
    localparam logic [MAC_MAX_ACC_W-1:0] MIN64 = acc_limit(ACC_W, 1'b0);
    localparam logic [ACC_W-1:0]         MAX_V = MAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0]         MIN_V = MIN64[ACC_W-1:0];

    logic [ACC_W:0] wide;

    // The extra top bit carries the true sign; it disagreeing with bit ACC_W-1 means overflow.
    always_comb begin
        wide = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        sum  = wide[ACC_W-1:0];
        if (ovf && (MODE == MAC_SAT)) begin
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/mac_pe_sys.sv
// Pipelined signed multiply-accumulate cell for the systolic array: operand
// forwarding, dot-product framing with clr/last, registered result.
module mac_pe_sys
    import mac_pkg::*;
#(
    parameter int          DW    = 8,
    parameter int          ACC_W = 24,
    parameter int unsigned SAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    input  logic                    clr,
    input  logic                    last,
    output logic signed [DW-1:0]    a_out,
    output logic signed [DW-1:0]    b_out,
    output logic                    fwd_valid,
    output logic                    fwd_clr,
    output logic                    fwd_last,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] result,
    output logic                    out_valid,
    output logic                    overflow
);

    `MAC_WIDTH_CHECK(DW, ACC_W)

    localparam mac_sat_t MODE = (SAT != 0) ? MAC_SAT : MAC_WRAP;

    // Handshake: in_valid qualifies a, b, clr and last for one cycle; there is no
    // ready, so every valid beat is consumed. out_valid is a one-cycle pulse.
    logic                    s1_valid;
    logic                    s1_clr;
    logic                    s1_last;
    logic signed [ACC_W-1:0] prod;
    logic signed [2*DW-1:0]  mul;
    logic signed [ACC_W-1:0] mul_ext;
    logic signed [ACC_W-1:0] add_base;
    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;

    assign mul      = a * b;
    assign mul_ext  = ACC_W'(mul);
    assign add_base = s1_clr ? '0 : acc;

    mac_sat_add #(
        .ACC_W (ACC_W),
        .MODE  (MODE)
    ) u_add (
        .x   (add_base),
        .y   (prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out     <= '0;
            b_out     <= '0;
            fwd_valid <= 1'b0;
            fwd_clr   <= 1'b0;
            fwd_last  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_clr    <= 1'b0;
            s1_last   <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            fwd_valid <= in_valid;
            fwd_clr   <= in_valid & clr;
            fwd_last  <= in_valid & last;
            if (in_valid) begin
                a_out <= a;
                b_out <= b;
            end

            s1_valid <= in_valid;
            s1_clr   <= in_valid & clr;
            s1_last  <= in_valid & last;
            prod     <= mul_ext;

            out_valid <= s1_valid & s1_last;
            // A clr beat starts a fresh overflow history before its own add is judged.
            if (s1_valid) begin
                acc      <= add_sum;
                overflow <= (overflow & ~s1_clr) | add_ovf;
                if (s1_last) begin
                    result <= add_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pe_sys.sv
// Bench for mac_pe_sys: a saturating and a wrapping 16-bit instance share one
// input stream; results are scored against an integer reference model.
module tb_mac_pe_sys;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic       last;

    logic [7:0]  a_out_s, b_out_s, a_out_w, b_out_w;
    logic        fv_s, fc_s, fl_s, fv_w, fc_w, fl_w;
    logic [15:0] acc_s, res_s, acc_w, res_w;
    logic        ov_s, ovf_s, ov_w, ovf_w;

    int n_compared;
    int n_mismatched;

    logic [16:0] exp_sat_q[$];
    logic [16:0] exp_wrap_q[$];
    int          m_acc[2];
    logic        m_ovf[2];

    mac_pe_sys #(.DW(8), .ACC_W(16), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr), .last(last),
        .a_out(a_out_s), .b_out(b_out_s), .fwd_valid(fv_s), .fwd_clr(fc_s), .fwd_last(fl_s),
        .acc(acc_s), .result(res_s), .out_valid(ov_s), .overflow(ovf_s)
    );

    mac_pe_sys #(.DW(8), .ACC_W(16), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr), .last(last),
        .a_out(a_out_w), .b_out(b_out_w), .fwd_valid(fv_w), .fwd_clr(fc_w), .fwd_last(fl_w),
        .acc(acc_w), .result(res_w), .out_valid(ov_w), .overflow(ovf_w)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: index 0 = saturating, 1 = wrapping
    task automatic model_beat(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic l);
        int p;
        int s;
        logic [15:0] lo;
        p = int'($signed(av)) * int'($signed(bv));
        for (int m = 0; m < 2; m++) begin
            s = (c ? 0 : m_acc[m]) + p;
            if (c) m_ovf[m] = 1'b0;
            if (s > 32767 || s < -32768) begin
                m_ovf[m] = 1'b1;
                if (m == 0) begin
                    s = (s > 0) ? 32767 : -32768;
                end else begin
                    lo = s[15:0];
                    s  = int'($signed(lo));
                end
            end
            m_acc[m] = s;
        end
        if (l) begin
            exp_sat_q.push_back({m_ovf[0], 16'(m_acc[0])});
            exp_wrap_q.push_back({m_ovf[1], 16'(m_acc[1])});
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_acc[m] = 0;
            m_ovf[m] = 1'b0;
        end
    endtask

    // driver tasks
    task automatic drive_beat(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic l);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        clr      = c;
        last     = l;
        model_beat(av, bv, c, l);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = 8'($urandom_range(0, 255));
            b        = 8'($urandom_range(0, 255));
            clr      = 1'($urandom_range(0, 1));
            last     = 1'($urandom_range(0, 1));
        end
    endtask

    // scoreboard: pop one expected {overflow, result} per out_valid pulse
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            if (ov_s) begin
                if (exp_sat_q.size() == 0) check("sat_unexpected_out_valid", 32'd1, 32'd0);
                else begin
                    e = exp_sat_q.pop_front();
                    check("sat_result", {15'd0, ovf_s, res_s}, {15'd0, e});
                end
            end
            if (ov_w) begin
                if (exp_wrap_q.size() == 0) check("wrap_unexpected_out_valid", 32'd1, 32'd0);
                else begin
                    e = exp_wrap_q.pop_front();
                    check("wrap_result", {15'd0, ovf_w, res_w}, {15'd0, e});
                end
            end
        end
    end

    initial begin
        int len;
        n_compared   = 0;
        n_mismatched = 0;
        model_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        clr      = 1'b0;
        last     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_a_out", a_out_s, 8'd0);
        check("rst_b_out", b_out_s, 8'd0);
        check("rst_fwd_valid", fv_s, 1'b0);
        check("rst_acc", acc_s, 16'd0);
        check("rst_result", res_w, 16'd0);
        check("rst_out_valid", ov_s, 1'b0);
        check("rst_overflow", ovf_s, 1'b0);

        // legacy sequence with latency check
        drive_beat(8'd3, 8'd4, 1'b1, 1'b0);
        drive_beat(8'd2, 8'hFF, 1'b0, 1'b0);
        drive_beat(8'hFB, 8'd2, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        check("legacy_early_out_valid", ov_s, 1'b0);
        @(negedge clk);
        check("legacy_out_valid", ov_s, 1'b1);
        check("legacy_result", res_s, 16'd0);
        check("legacy_overflow", ovf_s, 1'b0);

        // saturation vs wrap
        drive_beat(8'h80, 8'h80, 1'b1, 1'b0);
        drive_beat(8'h80, 8'h80, 1'b0, 1'b0);
        drive_beat(8'h80, 8'h80, 1'b0, 1'b1);
        idle(3);
        check("sat_result_const", res_s, 16'h7FFF);
        check("sat_overflow_const", ovf_s, 1'b1);
        check("wrap_result_const", res_w, 16'hC000);
        check("wrap_overflow_const", ovf_w, 1'b1);

        // bubbles and back-to-back dot products
        drive_beat(8'd1, 8'd1, 1'b1, 1'b0);
        idle(1);
        drive_beat(8'd2, 8'd2, 1'b0, 1'b1);
        drive_beat(8'd3, 8'd3, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check("b2b_first", res_s, 16'd5);
        @(negedge clk);
        check("b2b_second", res_s, 16'd9);
        check("b2b_second_pulse", ov_s, 1'b1);
        @(negedge clk);
        check("b2b_pulse_drop", ov_s, 1'b0);
        check("b2b_hold", res_s, 16'd9);
        check("b2b_ovf_clear", ovf_s, 1'b0);

        // forwarding
        drive_beat(8'd7, 8'hFD, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check("fwd_a_out", a_out_s, 8'd7);
        check("fwd_b_out", b_out_s, 8'hFD);
        check("fwd_valid", fv_s, 1'b1);
        check("fwd_clr", fc_s, 1'b0);
        @(negedge clk);
        check("fwd_valid_drop", fv_s, 1'b0);
        check("fwd_a_hold", a_out_s, 8'd7);
        check("fwd_b_hold", b_out_w, 8'hFD);

        // reset mid-operation
        idle(4);
        check("pre_rst_queue_empty", 32'(exp_sat_q.size() + exp_wrap_q.size()), 32'd0);
        drive_beat(8'd5, 8'd5, 1'b1, 1'b0);
        drive_beat(8'd1, 8'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'd2;
        b        = 8'd2;
        clr      = 1'b0;
        last     = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        last     = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_acc", acc_s, 16'd0);
        check("midrst_result", res_s, 16'd0);
        check("midrst_overflow", ovf_w, 1'b0);
        check("midrst_out_valid", ov_s, 1'b0);
        idle(4);

        // random framed dot products
        for (int i = 0; i < 1000; i++) begin
            len = $urandom_range(1, 16);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                drive_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                           (j == 0), (j == len - 1));
            end
        end

        // drain with a bounded wait
        for (int k = 0; k < 20 && (exp_sat_q.size() + exp_wrap_q.size()) != 0; k++) idle(1);
        idle(2);
        check("drain_sat_queue", 32'(exp_sat_q.size()), 32'd0);
        check("drain_wrap_queue", 32'(exp_wrap_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mac_pe_sys.md
# mac_pe_sys

Parametrised, pipelined signed multiply-accumulate processing element and successor to `mac_pe`. It adds valid-qualified input beats, explicit dot-product framing (`clr`/`last`), a registered result with `out_valid`, optional saturation with a sticky overflow flag, and registered systolic forwarding of operands so instances tile into a 1-D or 2-D array. It sits inside the systolic array fabric, one instance per cell.

## Interface
- `DW`, 8: operand width, signed two's complement.
- `ACC_W`, 24: accumulator and result width, signed. Legal range is `ACC_W >= 2*DW`.
- `SAT`, 1: 1 clamps the accumulator to the signed `ACC_W` range; 0 wraps modulo 2^ACC_W.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat qualifier for `a`, `b`, `clr`, `last`.
- `a`  in  DW  signed operand A.
- `b`  in  DW  signed operand B.
- `clr`  in  1  first beat of a dot product; the accumulator restarts from this beat's product.
- `last`  in  1  final beat of a dot product; triggers the result update.
- `a_out`  out  DW  registered copy of `a`, forwarded to the east neighbour.
- `b_out`  out  DW  registered copy of `b`, forwarded to the south neighbour.
- `fwd_valid`, `fwd_clr`, `fwd_last`  out  1 each  registered copies of `in_valid`, `clr`, `last`.
- `acc`  out  ACC_W  running accumulator, for debug only.
- `result`  out  ACC_W  completed dot product; holds its value until the next completion.
- `out_valid`  out  1  one-cycle pulse when `result` updates.
- `overflow`  out  1  sticky: set if any accumulation in the current dot product saturated or wrapped.

## Operation
- **Stage 0 (forwarding):** every edge, `fwd_valid<=in_valid`, `fwd_clr<=in_valid&clr`, `fwd_last<=in_valid&last`.
  - `a_out`/`b_out` load only when `in_valid=1`; otherwise they hold.
- **Stage 1 (multiply):** `prod <= a*b`, full `2*DW` signed width, sign-extended to `ACC_W`. The stage-1 valid/clr/last bits register alongside the product.
- **Stage 2 (accumulate), when stage-1 valid=1:**
  - If `clr=1`: `sum = 0 + prod`. `overflow` clears before this beat's evaluation.
  - Else: `sum = acc + prod`, computed in `ACC_W+1` bits.
  - If `sum` exceeds the signed `ACC_W` range:
    - `SAT=1`: `acc` loads `+2^(ACC_W-1)-1` or `-2^(ACC_W-1)`.
    - `SAT=0`: `acc` loads the low `ACC_W` bits.
    - In both modes `overflow` is set.
  - If `last=1`: `result <= new acc` and `out_valid <= 1` on the same edge. `overflow` remains readable alongside `result` until the next `clr` beat.
- When stage-1 valid=0 (bubble), `acc`, `result` and `overflow` hold and `out_valid <= 0`. Bubbles are allowed anywhere, including between `clr` and `last`.
- `clr` and `last` on the same beat form a single-term dot product: `result = a*b`.
- `last` without a prior `clr` continues accumulating from the current `acc`, which is the legacy `mac_pe` free-running behaviour.
- There is no backpressure; every valid beat is accepted.

## Timing
- **Reset values:** all outputs and internal pipeline registers are 0 (`a_out`, `b_out`, `acc`, `result`, `overflow`, and all valid bits).
- **Reset mid-operation:** beats in flight are dropped. There is no `out_valid` for a dot product interrupted by `rst`.
- **Latency:** a beat sampled at edge k is forwarded at edge k and updates `acc` at edge k+1. For a `last` beat, `result`/`out_valid` appear after edge k+1, a latency of 2 cycles.
- **Throughput:** one beat per cycle. Back-to-back dot products are supported: `last` on beat n and `clr` on beat n+1 produce no dead cycle.
- `out_valid` is never high for two consecutive cycles unless consecutive beats both carry `last`.

## Structure
- Shared package `mac_pkg` holds:
  - `mac_sat_t` mode constants (`MAC_WRAP=0`, `MAC_SAT=1`).
  - A function returning the `ACC_W` signed max/min.
  - A width-check macro for `ACC_W >= 2*DW`.
- Sub-module `mac_sat_add`: combinational `ACC_W`-bit signed add with `SAT` select and an overflow output. It is reusable by the array's reduction tree.

## Test plan
- **Legacy sequence:** `DW=8, ACC_W=16`; beats (3,4,clr), (2,-1), (-5,2,last). Required: `out_valid` pulses 2 cycles after the last beat, `result=0`, `overflow=0`.
- **Saturation:** `SAT=1, ACC_W=16`; 3 beats of (-128,-128), i.e. 16384 each, with `clr` on the first and `last` on the third. Required: `result=32767`, `overflow=1`. The same stimulus with `SAT=0` requires `result=-16384`, `overflow=1`.
- **Bubbles and back-to-back:** (1,1,clr), idle, (2,2,last), then immediately (3,3,clr+last). Required: `result=5` then `result=9` on consecutive `out_valid` pulses, with the earlier value held between pulses.
- **Forwarding:** `a=7, b=-3, in_valid=1` at edge k. Required: `a_out=7`, `b_out=-3`, `fwd_valid=1` after edge k. With `in_valid=0` the next cycle, `fwd_valid=0` and `a_out`/`b_out` hold.
- **Reset mid-operation:** beats (5,5,clr), (1,1), then `rst=1` on the cycle the `last` beat is presented. Required: no `out_valid`, and `acc`/`result`/`overflow`=0 after the reset edge.
- **Random self-check:** 1000 random framed dot products, lengths 1–16, random bubbles, compared against a behavioural reference model for both `SAT` values.
